// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: FSM state codes, opcodes,
// ALU operation codes and the datapath control word.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StMemAdr  = 4'd2,
    StMemRd   = 4'd3,
    StMemWb   = 4'd4,
    StMemWr   = 4'd5,
    StRtypeEx = 4'd6,
    StRtypeWb = 4'd7,
    StBeqEx   = 4'd8,
    StAddiEx  = 4'd9,
    StAddiWb  = 4'd10,
    StJEx     = 4'd11,
    StTrap    = 4'd12
  } ctrl_state_e;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpJ     = 6'b000010;

  // Consumed by the ALU control unit as well.
  typedef enum logic [1:0] {
    AluAdd   = 2'b00,
    AluSub   = 2'b01,
    AluFunct = 2'b10
  } alu_op_e;

  localparam logic [1:0] SrcBReg      = 2'b00;
  localparam logic [1:0] SrcBFour     = 2'b01;
  localparam logic [1:0] SrcBImm      = 2'b10;
  localparam logic [1:0] SrcBImmShift = 2'b11;

  localparam logic [1:0] PcAlu    = 2'b00;
  localparam logic [1:0] PcBranch = 2'b01;
  localparam logic [1:0] PcJump   = 2'b10;

  typedef struct packed {
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic       pc_write;
    logic [1:0] alu_src_b;
    alu_op_e    alu_op;
    logic [1:0] pc_src;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/ctrl_decode.sv
// State-to-control decode for the multicycle controller; purely combinational.
// Only the FETCH strobes and the branch PC write look at anything besides the state.
module ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  ctrl_state_e state,
  input  logic        mem_ready,
  input  logic        zero,
  output ctrl_t       ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      StFetch: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SrcBFour;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      StDecode: ctrl.alu_src_b = SrcBImmShift;
      StMemAdr, StAddiEx: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SrcBImm;
      end
      StMemRd: begin
        ctrl.iord     = 1'b1;
        ctrl.mem_read = 1'b1;
      end
      StMemWr: begin
        ctrl.iord      = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      StMemWb: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      StAddiWb: ctrl.reg_write = 1'b1;
      StRtypeWb: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      StRtypeEx: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = AluFunct;
      end
      StBeqEx: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = AluSub;
        ctrl.pc_src    = PcBranch;
        ctrl.pc_write  = zero;
      end
      StJEx: begin
        ctrl.pc_src   = PcJump;
        ctrl.pc_write = 1'b1;
      end
      StTrap:  ctrl.illegal = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS main controller: Moore FSM sequencing fetch/decode/execute phases
// plus a retired-instruction counter.
module multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned RETW = 16
) (
  input  logic            iclk,
  input  logic            irst_n,
  input  logic [5:0]      iop,
  input  logic            izero,
  input  logic            imem_ready,
  output logic            oIorD,
  output logic            oMemRead,
  output logic            oMemWrite,
  output logic            oIRWrite,
  output logic            oMemtoReg,
  output logic            oRegDst,
  output logic            oRegWrite,
  output logic            oALUSrcA,
  output logic            oPCWrite,
  output logic [1:0]      oALUSrcB,
  output logic [1:0]      oALUOp,
  output logic [1:0]      oPCSrc,
  output logic [3:0]      ostate,
  output logic            oillegal,
  output logic [RETW-1:0] oinstret
);

  ctrl_state_e     state_q, state_d;
  logic [RETW-1:0] instret_q;
  logic            retire;
  ctrl_t           ctrl;

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      StFetch: if (imem_ready) state_d = StDecode;
      StDecode: begin
        case (iop)
          OpRtype:    state_d = StRtypeEx;
          OpLw, OpSw: state_d = StMemAdr;
          OpBeq:      state_d = StBeqEx;
          OpAddi:     state_d = StAddiEx;
          OpJ:        state_d = StJEx;
          default:    state_d = StTrap;
        endcase
      end
      StMemAdr:  state_d = (iop == OpLw) ? StMemRd : StMemWr;
      StMemRd:   if (imem_ready) state_d = StMemWb;
      StMemWr: begin
        if (imem_ready) begin
          state_d = StFetch;
          retire  = 1'b1;
        end
      end
      StRtypeEx: state_d = StRtypeWb;
      StAddiEx:  state_d = StAddiWb;
      StMemWb, StRtypeWb, StAddiWb, StBeqEx, StJEx: begin
        state_d = StFetch;
        retire  = 1'b1;
      end
      // A trapped instruction goes back to fetch without counting as retired.
      StTrap:    state_d = StFetch;
      default:   state_d = StFetch;
    endcase
  end

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      state_q   <= StFetch;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire) instret_q <= instret_q + RETW'(1);
    end
  end

  // Gating ready with reset keeps IRWrite/PCWrite quiet while reset is held.
  ctrl_decode u_decode (
    .state     (state_q),
    .mem_ready (imem_ready & irst_n),
    .zero      (izero),
    .ctrl      (ctrl)
  );

  assign oIorD     = ctrl.iord;
  assign oMemRead  = ctrl.mem_read;
  assign oMemWrite = ctrl.mem_write;
  assign oIRWrite  = ctrl.ir_write;
  assign oMemtoReg = ctrl.mem_to_reg;
  assign oRegDst   = ctrl.reg_dst;
  assign oRegWrite = ctrl.reg_write;
  assign oALUSrcA  = ctrl.alu_src_a;
  assign oPCWrite  = ctrl.pc_write;
  assign oALUSrcB  = ctrl.alu_src_b;
  assign oALUOp    = ctrl.alu_op;
  assign oPCSrc    = ctrl.pc_src;
  assign oillegal  = ctrl.illegal;
  assign ostate    = state_q;
  assign oinstret  = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed sequences, an instruction table,
// and randomized traffic checked against a per-instruction path model.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] iop;
  logic       izero;
  logic       ready;

  logic        iord, mrd, mwr, irw, m2r, rdst, rw, srca, pcw, ill;
  logic [1:0]  srcb, aluop, pcsrc;
  logic [3:0]  st;
  logic [15:0] ret;
  logic        iord4, mrd4, mwr4, irw4, m2r4, rdst4, rw4, srca4, pcw4, ill4;
  logic [1:0]  srcb4, aluop4, pcsrc4;
  logic [3:0]  st4;
  logic [3:0]  ret4;

  logic [15:0] act, act4;
  assign act  = {iord, mrd, mwr, irw, m2r, rdst, rw, srca, pcw, srcb, aluop, pcsrc, ill};
  assign act4 = {iord4, mrd4, mwr4, irw4, m2r4, rdst4, rw4, srca4, pcw4, srcb4, aluop4,
                 pcsrc4, ill4};

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.RETW(16)) dut (
    .iclk(clk), .irst_n(rst_n), .iop(iop), .izero(izero), .imem_ready(ready),
    .oIorD(iord), .oMemRead(mrd), .oMemWrite(mwr), .oIRWrite(irw), .oMemtoReg(m2r),
    .oRegDst(rdst), .oRegWrite(rw), .oALUSrcA(srca), .oPCWrite(pcw), .oALUSrcB(srcb),
    .oALUOp(aluop), .oPCSrc(pcsrc), .ostate(st), .oillegal(ill), .oinstret(ret)
  );

  multicycle_ctrl #(.RETW(4)) dut4 (
    .iclk(clk), .irst_n(rst_n), .iop(iop), .izero(izero), .imem_ready(ready),
    .oIorD(iord4), .oMemRead(mrd4), .oMemWrite(mwr4), .oIRWrite(irw4), .oMemtoReg(m2r4),
    .oRegDst(rdst4), .oRegWrite(rw4), .oALUSrcA(srca4), .oPCWrite(pcw4), .oALUSrcB(srcb4),
    .oALUOp(aluop4), .oPCSrc(pcsrc4), .ostate(st4), .oillegal(ill4), .oinstret(ret4)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, got, want, $time);
    end
  endtask

  // Expected control word straight from the per-state output table.
  function automatic logic [15:0] exp_ctrl(input int s, input logic rdy, input logic z);
    logic e_iord, e_mrd, e_mwr, e_irw, e_m2r, e_rdst, e_rw, e_srca, e_pcw, e_ill;
    logic [1:0] e_srcb, e_aluop, e_pcsrc;
    {e_iord, e_mrd, e_mwr, e_irw, e_m2r, e_rdst, e_rw, e_srca, e_pcw, e_ill} = '0;
    e_srcb = 2'b00; e_aluop = 2'b00; e_pcsrc = 2'b00;
    case (s)
      0:  begin e_mrd = 1; e_srcb = 2'b01; e_irw = rdy; e_pcw = rdy; end
      1:  e_srcb = 2'b11;
      2, 9: begin e_srca = 1; e_srcb = 2'b10; end
      3:  begin e_iord = 1; e_mrd = 1; end
      4:  begin e_rw = 1; e_m2r = 1; end
      5:  begin e_iord = 1; e_mwr = 1; end
      6:  begin e_srca = 1; e_aluop = 2'b10; end
      7:  begin e_rw = 1; e_rdst = 1; end
      8:  begin e_srca = 1; e_aluop = 2'b01; e_pcsrc = 2'b01; e_pcw = z; end
      10: e_rw = 1;
      11: begin e_pcsrc = 2'b10; e_pcw = 1; end
      12: e_ill = 1;
      default: ;
    endcase
    return {e_iord, e_mrd, e_mwr, e_irw, e_m2r, e_rdst, e_rw, e_srca, e_pcw, e_srcb, e_aluop,
            e_pcsrc, e_ill};
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic look(input int s, input string tag);
    #1;
    check({tag, "_state"}, 32'(st), 32'(s));
    check({tag, "_ctrl"}, 32'(act), 32'(exp_ctrl(s, ready & rst_n, izero)));
  endtask

  task automatic step(input int s, input string tag);
    look(s, tag);
    tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ready = 1'b1;
    #1;
    check("rst_state", 32'(st), 32'd0);
    check("rst_instret", 32'(ret), 32'd0);
    check("rst_ctrl", 32'(act), 32'(exp_ctrl(0, 1'b0, 1'b0)));
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_instr(input logic [5:0] op, input logic z, output int cyc);
    iop = op; izero = z; ready = 1'b1; cyc = 0;
    do begin
      tick();
      cyc++;
    end while (st != 4'd0 && cyc < 20);
  endtask

  // Random-phase model: the full state path of one instruction, built from its opcode.
  int path[$];

  function automatic void build_path(input logic [5:0] op);
    path = {0, 1};
    case (op)
      6'b000000: path = {path, 6, 7};
      6'b100011: path = {path, 2, 3, 4};
      6'b101011: path = {path, 2, 5};
      6'b000100: path.push_back(8);
      6'b001000: path = {path, 9, 10};
      6'b000010: path.push_back(11);
      default:   path.push_back(12);
    endcase
  endfunction

  typedef struct {
    logic [5:0] op;
    logic       z;
    int         cyc;
    int         inc;
  } vec_t;

  vec_t vecs[9];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int pos;
    int model_ret;
    logic [15:0] ret0;
    logic [5:0] ops[8];

    vecs[0] = '{6'b000000, 1'b0, 4, 1};
    vecs[1] = '{6'b100011, 1'b0, 5, 1};
    vecs[2] = '{6'b101011, 1'b0, 4, 1};
    vecs[3] = '{6'b000100, 1'b1, 3, 1};
    vecs[4] = '{6'b000100, 1'b0, 3, 1};
    vecs[5] = '{6'b001000, 1'b0, 4, 1};
    vecs[6] = '{6'b000010, 1'b0, 3, 1};
    vecs[7] = '{6'b111111, 1'b0, 3, 0};
    vecs[8] = '{6'b010101, 1'b1, 3, 0};

    iop = 6'd0; izero = 1'b0;
    do_reset();

    // R-type with memory always ready.
    iop = 6'b000000; ready = 1'b1;
    step(0, "r_f"); step(1, "r_d"); step(6, "r_ex"); step(7, "r_wb"); look(0, "r_end");
    check("r_instret", 32'(ret), 32'd1);

    // lw with two wait cycles in MEMRD.
    iop = 6'b100011;
    step(0, "lw_f"); step(1, "lw_d"); step(2, "lw_adr");
    ready = 1'b0; step(3, "lw_rd0"); step(3, "lw_rd1");
    ready = 1'b1; step(3, "lw_rd2"); step(4, "lw_wb"); look(0, "lw_end");
    check("lw_instret", 32'(ret), 32'd2);

    // beq taken then not taken.
    iop = 6'b000100; izero = 1'b1;
    step(0, "beq1_f"); step(1, "beq1_d"); look(8, "beq1_ex");
    check("beq1_pcwrite", 32'(pcw), 32'd1);
    check("beq1_pcsrc", 32'(pcsrc), 32'd1);
    tick();
    izero = 1'b0;
    step(0, "beq0_f"); step(1, "beq0_d"); look(8, "beq0_ex");
    check("beq0_pcwrite", 32'(pcw), 32'd0);
    tick();
    look(0, "beq_end");
    check("beq_instret", 32'(ret), 32'd4);

    // Unsupported opcode traps without retiring.
    iop = 6'b111111;
    step(0, "ill_f"); step(1, "ill_d"); look(12, "ill_trap");
    check("ill_pulse", 32'(ill), 32'd1);
    tick();
    look(0, "ill_end");
    check("ill_pulse_off", 32'(ill), 32'd0);
    check("ill_instret", 32'(ret), 32'd4);

    // Instruction table, memory always ready.
    foreach (vecs[i]) begin
      ret0 = ret;
      run_instr(vecs[i].op, vecs[i].z, cyc);
      check($sformatf("tbl%0d_cycles", i), 32'(cyc), 32'(vecs[i].cyc));
      check($sformatf("tbl%0d_retire", i), 32'(ret - ret0), 32'(vecs[i].inc));
    end

    // Reset asserted asynchronously while sw waits in MEMWR.
    iop = 6'b101011; ready = 1'b1;
    step(0, "sw_f"); step(1, "sw_d"); step(2, "sw_adr");
    ready = 1'b0; look(5, "sw_wr");
    #2;
    rst_n = 1'b0; ready = 1'b1;
    #1;
    check("mid_rst_state", 32'(st), 32'd0);
    check("mid_rst_instret", 32'(ret), 32'd0);
    check("mid_rst_memwrite", 32'(mwr), 32'd0);
    check("mid_rst_irwrite", 32'(irw), 32'd0);
    check("mid_rst_pcwrite", 32'(pcw), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Counter wrap on the 4-bit instance.
    for (int i = 0; i < 15; i++) run_instr(6'b000010, 1'b0, cyc);
    check("wrap_pre4", 32'(ret4), 32'd15);
    check("wrap_pre16", 32'(ret), 32'd15);
    run_instr(6'b000010, 1'b0, cyc);
    check("wrap4", 32'(ret4), 32'd0);
    check("wrap16", 32'(ret), 32'd16);

    // Randomized traffic.
    ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010,
            6'b111111, 6'b000000};
    do_reset();
    model_ret = 0;
    pos = 0;
    for (int n = 0; n < 300; ) begin
      if (pos == 0) begin
        ops[7] = 6'($urandom_range(63));
        iop = ops[$urandom_range(7)];
        build_path(iop);
      end
      ready = ($urandom_range(3) != 0);
      izero = 1'($urandom_range(1));
      look(path[pos], "rnd");
      check("rnd_instret", 32'(ret), 32'(model_ret[15:0]));
      check("rnd_instret4", 32'(ret4), 32'(model_ret % 16));
      check("rnd_state4", 32'(st4), 32'(path[pos]));
      check("rnd_ctrl4", 32'(act4), 32'(exp_ctrl(path[pos], ready, izero)));
      if (!((path[pos] == 0 || path[pos] == 3 || path[pos] == 5) && !ready)) begin
        pos++;
        if (pos == path.size()) begin
          if (path[pos-1] != 12) model_ret++;
          pos = 0;
          n++;
        end
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter RETW, default 16, width of retired-instruction counter.
REQ-002 SHALL have port iclk  input  1  sole clock, rising edge.
REQ-003 SHALL have port irst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port iop  input  6  opcode field of instruction register.
REQ-005 SHALL have port izero  input  1  ALU zero flag.
REQ-006 SHALL have port imem_ready  input  1  memory completes access this cycle.
REQ-007 SHALL have ports oIorD, oMemRead, oMemWrite, oIRWrite, oMemtoReg, oRegDst, oRegWrite, oALUSrcA, oPCWrite  output  1  each.
REQ-008 SHALL have ports oALUSrcB, oALUOp, oPCSrc  output  2  each; oALUOp feeds the ALU control unit (00 add, 01 sub, 10 funct).
REQ-009 SHALL have ports ostate  output  4  current state; oillegal  output  1  unsupported-opcode pulse; oinstret  output  RETW  retired count.

Function
REQ-010 SHALL be a Moore FSM; all outputs decode from the state register only, except oPCWrite in BEQEX (izero) and the FETCH strobes (imem_ready).
REQ-011 SHALL encode states FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, RTYPEWB=7, BEQEX=8, ADDIEX=9, ADDIWB=10, JEX=11, TRAP=12; codes 13-15 go to FETCH next cycle with all strobes 0.
REQ-012 SHALL hold FETCH while imem_ready=0; on imem_ready=1 go to DECODE.
REQ-013 SHALL decode in DECODE: 000000->RTYPEEX, 100011/101011->MEMADR, 000100->BEQEX, 001000->ADDIEX, 000010->JEX, others->TRAP.
REQ-014 SHALL go MEMADR->MEMRD if iop=100011, else MEMWR.
REQ-015 SHALL hold MEMRD and MEMWR while imem_ready=0; MEMRD->MEMWB, MEMWR->FETCH on imem_ready=1.
REQ-016 SHALL go RTYPEEX->RTYPEWB, ADDIEX->ADDIWB; MEMWB, RTYPEWB, ADDIWB, BEQEX, JEX, TRAP->FETCH unconditionally.
REQ-017 SHALL in FETCH drive MemRead=1, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00, IorD=0, and IRWrite=PCWrite=imem_ready.
REQ-018 SHALL in DECODE drive ALUSrcA=0, ALUSrcB=11, ALUOp=00; in MEMADR/ADDIEX ALUSrcA=1, ALUSrcB=10, ALUOp=00.
REQ-019 SHALL in MEMRD drive IorD=1, MemRead=1; in MEMWR IorD=1, MemWrite=1.
REQ-020 SHALL in MEMWB drive RegWrite=1, MemtoReg=1, RegDst=0; in ADDIWB RegWrite=1, MemtoReg=0, RegDst=0; in RTYPEWB RegWrite=1, MemtoReg=0, RegDst=1.
REQ-021 SHALL in RTYPEEX drive ALUSrcA=1, ALUSrcB=00, ALUOp=10; in BEQEX ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, PCWrite=izero.
REQ-022 SHALL in JEX drive PCSrc=10, PCWrite=1; in TRAP oillegal=1 for exactly one cycle.
REQ-023 SHALL drive every strobe not listed for a state to 0 and every unlisted select to 00/0.
REQ-024 SHALL increment oinstret on each transition into FETCH from MEMWB, MEMWR, RTYPEWB, BEQEX, ADDIWB or JEX; not from TRAP; wraps modulo 2^RETW.
REQ-025 SHALL give instruction latency: R-type/addi 4, lw 5, sw 4, beq 3, j 3 cycles, each memory state stretched by wait cycles.

Reset
REQ-026 SHALL on irst_n=0 immediately force state FETCH and oinstret=0, independent of iclk.
REQ-027 SHALL during reset drive outputs per FETCH decode with imem_ready-gated strobes held 0, oillegal=0, ostate=0.
REQ-028 SHALL abandon any in-flight instruction on mid-operation reset without retiring it.

Structure
REQ-029 SHALL take state codes, opcode constants and ALUOp codes from shared package mips_ctrl_pkg, also used by the ALU control unit.
REQ-030 SHALL place state->control decode in one combinational sub-module ctrl_decode; the FSM and counter stay in multicycle_ctrl.

Verification
REQ-031 SHALL cover: reset, iop=000000, imem_ready=1 always -> states 0,1,6,7,0; RegWrite=1,RegDst=1 in state 7; oinstret=1.
REQ-032 SHALL cover: iop=100011, imem_ready low 2 cycles in MEMRD -> state 3 held 3 cycles, then 4 with MemtoReg=1; total 7 cycles.
REQ-033 SHALL cover: iop=000100 with izero=1 then izero=0 -> oPCWrite=1, PCSrc=01 in state 8, then oPCWrite=0; both retire.
REQ-034 SHALL cover: iop=111111 -> state 12, oillegal one-cycle pulse, back to 0, oinstret unchanged.
REQ-035 SHALL cover: irst_n low mid-MEMWR -> ostate=0 asynchronously, oinstret=0, MemWrite=0.
REQ-036 SHALL cover: RETW=4, 16 retired instructions -> oinstret wraps to 0.
